// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The grant state encoding doubles as the externally visible owner code.
package mem_arb_pkg;

  // Grant FSM states; the encoding is exported unchanged on the owner port
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } arb_state_e;

  // Port indices as stored in the last-served register
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Default width of the saturating contention counter
  localparam int CW_DEFAULT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on a tie the port that was not served last wins.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the request pair and the last-served port
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_i == PORT1) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified memory between the CPU (port 0) and a second
// bus master (port 1). A registered grant state selects which port drives the
// memory for one cycle; the granted port sees a one-cycle ack. Ties are broken
// round-robin, and cycles in which a requester is held off are counted.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wd,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wd,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rd,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [1:0]    owner,
  output logic [CW-1:0] conflicts
);

  localparam logic [CW-1:0] CONF_ONE = {{(CW-1){1'b0}}, 1'b1};

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] conflicts_q, conflicts_d;
  logic [1:0]    grant_s;
  logic          deny_s;

  rr_pick u_rr_pick (
    .req_i   ({m1_req, m0_req}),
    .last_i  (last_q),
    .grant_o (grant_s)
  );

  // A requester is being held off while the other port owns the memory
  assign deny_s = ((state_q == ST_G0) && m1_req) || ((state_q == ST_G1) && m0_req);

  // Next grant state, last-served port and saturating contention count
  always_comb begin
    state_d     = ST_IDLE;
    last_d      = last_q;
    conflicts_d = conflicts_q;
    case (grant_s)
      2'b01: begin
        state_d = ST_G0;
        last_d  = PORT0;
      end
      2'b10: begin
        state_d = ST_G1;
        last_d  = PORT1;
      end
      default: begin
        state_d = ST_IDLE;
        last_d  = last_q;
      end
    endcase
    if (deny_s && !(&conflicts_q)) begin
      conflicts_d = conflicts_q + CONF_ONE;
    end else begin
      conflicts_d = conflicts_q;
    end
  end

  // Grant FSM registers; after reset port 1 counts as last served so the CPU wins the first tie
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT1;
      conflicts_q <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      conflicts_q <= conflicts_d;
    end
  end

  // Route the owning port onto the memory bus and strobe its ack
  always_comb begin
    mem_we  = 1'b0;
    mem_adr = {AW{1'b0}};
    mem_wd  = {DW{1'b0}};
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    case (state_q)
      ST_G0: begin
        mem_we  = m0_we;
        mem_adr = m0_adr;
        mem_wd  = m0_wd;
        m0_ack  = 1'b1;
      end
      ST_G1: begin
        mem_we  = m1_we;
        mem_adr = m1_adr;
        mem_wd  = m1_wd;
        m1_ack  = 1'b1;
      end
      default: begin
        mem_we  = 1'b0;
        mem_adr = {AW{1'b0}};
        mem_wd  = {DW{1'b0}};
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
      end
    endcase
  end

  // Read data goes to both masters; each qualifies it with its own ack
  assign m0_rd     = mem_rd;
  assign m1_rd     = mem_rd;
  assign owner     = state_q;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations followed by randomized master traffic checked every cycle
// against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  r_req;
  logic [1:0]  r_we;
  logic [31:0] r_adr [2];
  logic [31:0] r_wd  [2];

  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_adr, m1_adr, m0_wd, m1_wd;
  logic        m0_ack, m1_ack, mem_we;
  logic [31:0] m0_rd, m1_rd, mem_adr, mem_wd, mem_rd;
  logic [1:0]  owner;
  logic [15:0] conflicts;

  logic        m0_ack4, m1_ack4, mem_we4;
  logic [31:0] m0_rd4, m1_rd4, mem_adr4, mem_wd4, mem_rd4;
  logic [1:0]  owner4;
  logic [3:0]  conflicts4;

  logic [31:0] mem_arr   [0:255];
  logic [31:0] model_mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  // model state: owner 0 idle, 1 port0, 2 port1; last served port index
  int m_own   = 0;
  int m_last  = 1;
  int m_conf  = 0;
  bit m_valid = 1'b0;

  assign m0_req = r_req[0];
  assign m1_req = r_req[1];
  assign m0_we  = r_we[0];
  assign m1_we  = r_we[1];
  assign m0_adr = r_adr[0];
  assign m1_adr = r_adr[1];
  assign m0_wd  = r_wd[0];
  assign m1_wd  = r_wd[1];

  assign mem_rd  = mem_arr[mem_adr[9:2]];
  assign mem_rd4 = mem_arr[mem_adr4[9:2]];

  mem_arbiter #(.DW(32), .AW(32), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wd(m0_wd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wd(m1_wd),
    .m0_ack(m0_ack), .m0_rd(m0_rd), .m1_ack(m1_ack), .m1_rd(m1_rd),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .owner(owner), .conflicts(conflicts)
  );

  mem_arbiter #(.DW(32), .AW(32), .CW(4)) dut4 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wd(m0_wd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wd(m1_wd),
    .m0_ack(m0_ack4), .m0_rd(m0_rd4), .m1_ack(m1_ack4), .m1_rd(m1_rd4),
    .mem_we(mem_we4), .mem_adr(mem_adr4), .mem_wd(mem_wd4), .mem_rd(mem_rd4),
    .owner(owner4), .conflicts(conflicts4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = i;
    if (i == 4) return 32'h2002_0005;
    return 32'hA5A5_0000 ^ (v * 32'h0001_0003);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: combinational read, write committed at the clock edge
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem_arr[mem_adr[9:2]] <= mem_wd;
    end
  end

  // Compare process: check outputs mid-cycle, then advance the model across the coming edge
  initial begin
    logic        e_we;
    logic [31:0] e_adr, e_wd;
    int          win;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      e_we  = 1'b0;
      e_adr = 32'h0;
      e_wd  = 32'h0;
      if (m_own == 1) begin e_we = m0_we; e_adr = m0_adr; e_wd = m0_wd; end
      if (m_own == 2) begin e_we = m1_we; e_adr = m1_adr; e_wd = m1_wd; end
      if (m_valid) begin
        chk("owner", owner, m_own);
        chk("m0_ack", m0_ack, m_own == 1);
        chk("m1_ack", m1_ack, m_own == 2);
        chk("mem_we", mem_we, e_we);
        chk("mem_adr", mem_adr, e_adr);
        chk("mem_wd", mem_wd, e_wd);
        chk("conflicts", conflicts, (m_conf > 65535) ? 65535 : m_conf);
        chk("owner4", owner4, m_own);
        chk("acks4", {m1_ack4, m0_ack4}, {m_own == 2, m_own == 1});
        chk("mem_bus4", {mem_we4, mem_adr4, mem_wd4}, {e_we, e_adr, e_wd});
        chk("conflicts4", conflicts4, (m_conf > 15) ? 15 : m_conf);
        if (m_own == 1 && !m0_we) begin
          chk("m0_rd", m0_rd, model_mem[m0_adr[9:2]]);
          chk("m0_rd4", m0_rd4, model_mem[m0_adr[9:2]]);
        end
        if (m_own == 2 && !m1_we) begin
          chk("m1_rd", m1_rd, model_mem[m1_adr[9:2]]);
          chk("m1_rd4", m1_rd4, model_mem[m1_adr[9:2]]);
        end
        if (e_we) model_mem[e_adr[9:2]] = e_wd;
      end
      if (!reset) begin
        m_own   = 0;
        m_last  = 1;
        m_conf  = 0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        if ((m_own == 1 && m1_req) || (m_own == 2 && m0_req)) m_conf++;
        if (m0_req && m1_req) win = (m_last == 0) ? 1 : 0;
        else if (m0_req)      win = 0;
        else if (m1_req)      win = 1;
        else                  win = -1;
        if (win >= 0) begin
          m_own  = win + 1;
          m_last = win;
        end else begin
          m_own = 0;
        end
      end
    end
  end

  // Both ports request continuously for n grant cycles, then drain
  task automatic contend(input int n);
    int a0, a1, g;
    a0 = 0;
    a1 = 0;
    r_we = 2'b00;
    r_adr[0] = 32'h10;
    r_adr[1] = 32'h40;
    r_req = 2'b11;
    tick();
    for (int i = 0; i < n; i++) begin
      g = i % 2;
      if (i == n - 1) r_req[g] = 1'b0;
      #1;
      chk("alt_owner", owner, g + 1);
      a0 += int'(m0_ack);
      a1 += int'(m1_ack);
      tick();
    end
    g = n % 2;
    r_req[g] = 1'b0;
    #1;
    chk("drain_owner", owner, g + 1);
    tick();
    #1;
    chk("alt_acks0", a0, n / 2);
    chk("alt_acks1", a1, n - n / 2);
    chk("alt_conf", conflicts, n);
    chk("alt_conf4", conflicts4, (n > 15) ? 15 : n);
  endtask

  task automatic new_txn(input int k);
    r_we[k]  = ($urandom_range(0, 2) == 0);
    r_adr[k] = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    r_wd[k]  = $urandom;
  endtask

  // Main stimulus: directed scenarios, then random traffic
  initial begin
    bit nxt_new [2];
    int wait_c  [2];
    bit out_k   [2];
    logic ack_k;
    reset = 1'b0;
    r_req = 2'b00;
    r_we  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      r_adr[k] = 32'h0; r_wd[k] = 32'h0; nxt_new[k] = 1'b0; wait_c[k] = 0;
    end
    tick();
    tick();
    chk("rst_owner", owner, 2'b00);
    chk("rst_acks", {m1_ack, m0_ack}, 2'b00);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_conf", conflicts, 16'd0);

    // single uncontended read
    reset = 1'b1;
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_adr[0] = 32'h10;
    #1;
    chk("t1_idle", owner, 2'b00);
    tick();
    r_req[0] = 1'b0;
    #1;
    chk("t1_owner", owner, 2'b01);
    chk("t1_ack", {m1_ack, m0_ack}, 2'b01);
    chk("t1_rd", m0_rd, 32'h2002_0005);
    chk("t1_conf", conflicts, 16'd0);
    tick();

    // port 1 writes, then port 0 reads back
    r_req[1] = 1'b1; r_we[1] = 1'b1; r_adr[1] = 32'h40; r_wd[1] = 32'hDEAD_BEEF;
    #1;
    chk("t2_we_idle", mem_we, 1'b0);
    tick();
    r_req[1] = 1'b0;
    #1;
    chk("t2_owner", owner, 2'b10);
    chk("t2_we", mem_we, 1'b1);
    chk("t2_adr", mem_adr, 32'h40);
    chk("t2_wd", mem_wd, 32'hDEAD_BEEF);
    tick();
    r_we[1] = 1'b0;
    r_req[0] = 1'b1; r_adr[0] = 32'h40;
    #1;
    chk("t2_we_after", mem_we, 1'b0);
    tick();
    r_req[0] = 1'b0;
    #1;
    chk("t2_rd", m0_rd, 32'hDEAD_BEEF);
    chk("t2_we_rd", mem_we, 1'b0);
    tick();

    // simultaneous first requests after reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    r_req = 2'b11; r_adr[0] = 32'h10; r_adr[1] = 32'h40;
    tick();
    r_req[0] = 1'b0;
    #1;
    chk("t3_first", owner, 2'b01);
    tick();
    r_req[1] = 1'b0;
    #1;
    chk("t3_second", owner, 2'b10);
    chk("t3_rd", m1_rd, 32'hDEAD_BEEF);
    chk("t3_conf", conflicts, 16'd1);
    tick();

    // sustained contention: 10 cycles, then 20 cycles saturating the 4-bit counter
    reset = 1'b0;
    tick();
    reset = 1'b1;
    contend(10);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    contend(20);

    // reset during a port 1 write
    r_req[1] = 1'b1; r_we[1] = 1'b1; r_adr[1] = 32'h80; r_wd[1] = 32'hCAFE_F00D;
    tick();
    r_req[1] = 1'b0;
    reset = 1'b0;
    #1;
    chk("t5_owner", owner, 2'b10);
    chk("t5_we", mem_we, 1'b1);
    tick();
    reset = 1'b1;
    r_we[1] = 1'b0;
    r_req = 2'b11; r_adr[0] = 32'h80; r_adr[1] = 32'h10;
    #1;
    chk("t5_idle", owner, 2'b00);
    chk("t5_acks", {m1_ack, m0_ack}, 2'b00);
    chk("t5_conf", conflicts, 16'd0);
    tick();
    r_req[0] = 1'b0;
    #1;
    chk("t5_p0_wins", owner, 2'b01);
    chk("t5_rd", m0_rd, 32'hCAFE_F00D);
    tick();
    r_req[1] = 1'b0;
    tick();

    // random traffic with occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_k[0] = r_req[0];
      out_k[1] = r_req[1];
      reset = ($urandom_range(0, 149) != 0);
      for (int k = 0; k < 2; k++) begin
        if (nxt_new[k]) begin
          new_txn(k);
          r_req[k] = 1'b1;
          nxt_new[k] = 1'b0;
        end
        if (m_own == k + 1) begin
          r_req[k] = 1'($urandom_range(0, 1));
          nxt_new[k] = r_req[k];
        end else if (!r_req[k] && $urandom_range(0, 2) == 0) begin
          new_txn(k);
          r_req[k] = 1'b1;
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        ack_k = (k == 0) ? m0_ack : m1_ack;
        if (out_k[k]) begin
          if (ack_k) begin
            chk("latency", wait_c[k] <= 1, 1'b1);
            wait_c[k] = 0;
          end else begin
            wait_c[k]++;
          end
        end else begin
          wait_c[k] = 0;
        end
        if (!reset) wait_c[k] = -1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
